// File: rtl/sopc_counter_ram_arbiter.sv
// sopc_counter_ram_arbiter: two-requester round-robin arbiter in front of a single-port
// synchronous RAM with 1-cycle read return, per-owner routing and out-of-range guarding.
module sopc_counter_ram_arbiter #(
  parameter int DEPTH  = 5120,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,
  output logic              oor_err
);
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
  logic              r_last, r_rd_v, r_rd_own, r_rd_oor, r_oor;
  logic [31:0]       r_rd0, r_rd1;
  logic              w_act0, w_act1, w_gnt0, w_gnt1, w_acc, w_wr, w_oor;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_rdata;
  // reset_n gates grants so nothing is accepted until the first edge after release
  assign w_act0 = reset_n & (m0_read | m0_write);
  assign w_act1 = reset_n & (m1_read | m1_write);
  assign w_gnt0 = w_act0 & (~w_act1 | r_last);
  assign w_gnt1 = w_act1 & ~w_gnt0;
  assign w_acc  = w_gnt0 | w_gnt1;
  assign w_addr = w_gnt1 ? m1_address : m0_address;
  assign w_wr   = w_gnt1 ? m1_write : m0_write;
  assign w_oor  = {1'b0, w_addr} >= LP_DEPTH;
  assign m0_waitrequest = ~w_gnt0;
  assign m1_waitrequest = ~w_gnt1;
  assign ram_address    = w_addr;
  assign ram_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = w_gnt1 ? m1_writedata : m0_writedata;
  assign ram_chipselect = w_acc;
  assign ram_write      = w_acc & w_wr & ~w_oor;
  assign ram_clken      = 1'b1;
  assign oor_err        = r_oor;
  assign w_rdata          = r_rd_oor ? 32'h0 : ram_readdata;
  assign m0_readdatavalid = r_rd_v & ~r_rd_own;
  assign m1_readdatavalid = r_rd_v & r_rd_own;
  assign m0_readdata      = m0_readdatavalid ? w_rdata : r_rd0;
  assign m1_readdata      = m1_readdatavalid ? w_rdata : r_rd1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last   <= 1'b1;
      r_rd_v   <= 1'b0;
      r_rd_own <= 1'b0;
      r_rd_oor <= 1'b0;
      r_oor    <= 1'b0;
      r_rd0    <= 32'h0;
      r_rd1    <= 32'h0;
    end else begin
      r_last   <= w_acc ? w_gnt1 : r_last;
      r_rd_v   <= w_acc & ~w_wr;
      r_rd_own <= w_gnt1;
      r_rd_oor <= w_oor;
      r_oor    <= r_oor | (w_acc & w_oor);
      r_rd0    <= m0_readdatavalid ? w_rdata : r_rd0;
      r_rd1    <= m1_readdatavalid ? w_rdata : r_rd1;
    end
  end
endmodule

// File: tb/tb_sopc_counter_ram_arbiter.sv
// tb_sopc_counter_ram_arbiter: directed checks of arbitration, read routing, byte lanes,
// out-of-range handling and reset against a behavioural synchronous RAM.
module tb_sopc_counter_ram_arbiter;
  localparam int DEPTH  = 5120;
  localparam int ADDR_W = 13;
  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address, ram_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [3:0]        m0_byteenable, m1_byteenable, ram_byteenable;
  logic [31:0]       m0_writedata, m1_writedata, ram_writedata, ram_readdata;
  logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0]       m0_readdata, m1_readdata;
  logic              ram_chipselect, ram_write, ram_clken, oor_err;
  logic [31:0]       mem [0:DEPTH-1];
  int                n_chk = 0;
  int                n_err = 0;

  sopc_counter_ram_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .oor_err(oor_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      ram_readdata <= (int'(ram_address) < DEPTH) ? mem[ram_address] : 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_req(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic m1_req(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle();
    m0_req(0, 0, '0, 4'h0, 32'h0);
    m1_req(0, 0, '0, 4'h0, 32'h0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_w0"}, 32'(m0_waitrequest), 32'd1);
    chk({tag, "_w1"}, 32'(m1_waitrequest), 32'd1);
    chk({tag, "_v0"}, 32'(m0_readdatavalid), 32'd0);
    chk({tag, "_v1"}, 32'(m1_readdatavalid), 32'd0);
    chk({tag, "_d0"}, m0_readdata, 32'h0);
    chk({tag, "_d1"}, m1_readdata, 32'h0);
    chk({tag, "_cs"}, 32'(ram_chipselect), 32'd0);
    chk({tag, "_wr"}, 32'(ram_write), 32'd0);
    chk({tag, "_oor"}, 32'(oor_err), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC000_0000 | 32'(i);
    ram_readdata = 32'h0;
    reset_n = 1'b0;
    idle();
    m0_read = 1'b1;
    m1_read = 1'b1;
    #1;
    chk_reset_state("rst");
    chk("rst_clken", 32'(ram_clken), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle();
    cyc();
    // first tie after reset: m0 wins, m1 waits one cycle and then beats a fresh m0 request
    m0_req(1, 0, 13'h010, 4'hF, 32'h0);
    m1_req(1, 0, 13'h0FF, 4'hF, 32'h0);
    #1;
    chk("tie1_w0", 32'(m0_waitrequest), 32'd0);
    chk("tie1_w1", 32'(m1_waitrequest), 32'd1);
    chk("tie1_addr", 32'(ram_address), 32'h010);
    chk("tie1_cs", 32'(ram_chipselect), 32'd1);
    cyc();
    m0_req(1, 0, 13'h011, 4'hF, 32'h0);
    #1;
    chk("tie2_w1", 32'(m1_waitrequest), 32'd0);
    chk("tie2_w0", 32'(m0_waitrequest), 32'd1);
    chk("tie2_addr", 32'(ram_address), 32'h0FF);
    chk("tie2_v0", 32'(m0_readdatavalid), 32'd1);
    chk("tie2_d0", m0_readdata, 32'hC000_0010);
    cyc();
    m1_req(0, 0, '0, 4'h0, 32'h0);
    #1;
    chk("tie3_w0", 32'(m0_waitrequest), 32'd0);
    chk("tie3_v1", 32'(m1_readdatavalid), 32'd1);
    chk("tie3_v0", 32'(m0_readdatavalid), 32'd0);
    chk("tie3_d1", m1_readdata, 32'hC000_00FF);
    cyc();
    idle();
    #1;
    chk("tie4_v0", 32'(m0_readdatavalid), 32'd1);
    chk("tie4_d0", m0_readdata, 32'hC000_0011);
    cyc();
    m0_req(0, 1, 13'h010, 4'hF, 32'hA5A5_5A5A);
    #1;
    chk("wr0_w0", 32'(m0_waitrequest), 32'd0);
    chk("wr0_ramwr", 32'(ram_write), 32'd1);
    chk("wr0_wd", ram_writedata, 32'hA5A5_5A5A);
    cyc();
    m0_req(1, 0, 13'h010, 4'hF, 32'h0);
    #1;
    chk("rd0_ramwr", 32'(ram_write), 32'd0);
    cyc();
    idle();
    #1;
    chk("rd0_v0", 32'(m0_readdatavalid), 32'd1);
    chk("rd0_v1", 32'(m1_readdatavalid), 32'd0);
    chk("rd0_d0", m0_readdata, 32'hA5A5_5A5A);
    cyc();
    chk("hold_v0", 32'(m0_readdatavalid), 32'd0);
    chk("hold_d0", m0_readdata, 32'hA5A5_5A5A);
    chk("hold_d1", m1_readdata, 32'hC000_00FF);
    // byte-lane merge from m1
    m1_req(0, 1, 13'h0FF, 4'hF, 32'hFFFF_FFFF);
    cyc();
    m1_req(0, 1, 13'h0FF, 4'b0011, 32'h1122_3344);
    #1;
    chk("be_ram", 32'(ram_byteenable), 32'h3);
    chk("be_w1", 32'(m1_waitrequest), 32'd0);
    cyc();
    m1_req(1, 0, 13'h0FF, 4'hF, 32'h0);
    cyc();
    idle();
    #1;
    chk("be_v1", 32'(m1_readdatavalid), 32'd1);
    chk("be_d1", m1_readdata, 32'hFFFF_3344);
    cyc();
    m0_req(0, 1, 13'h020, 4'h0, 32'h1234_5678);
    #1;
    chk("be0_ramwr", 32'(ram_write), 32'd1);
    chk("be0_be", 32'(ram_byteenable), 32'h0);
    chk("be0_wd", ram_writedata, 32'h1234_5678);
    cyc();
    m0_req(1, 0, 13'h020, 4'hF, 32'h0);
    cyc();
    idle();
    #1;
    chk("be0_d0", m0_readdata, 32'hC000_0020);
    cyc();
    // alternating single-requester reads, one per cycle, each returning on its owner
    for (int k = 0; k <= 8; k++) begin
      idle();
      if (k < 8) begin
        if (k % 2 == 0) m0_req(1, 0, 13'(32'h40 + k), 4'hF, 32'h0);
        else            m1_req(1, 0, 13'(32'h40 + k), 4'hF, 32'h0);
      end
      #1;
      if (k < 8) chk($sformatf("alt%0d_acc", k), 32'(ram_chipselect), 32'd1);
      if (k > 0) begin
        chk($sformatf("alt%0d_v0", k), 32'(m0_readdatavalid), 32'(k % 2));
        chk($sformatf("alt%0d_v1", k), 32'(m1_readdatavalid), 32'((k + 1) % 2));
        chk($sformatf("alt%0d_d", k), (k % 2 == 1) ? m0_readdata : m1_readdata,
            32'hC000_0040 + 32'(k - 1));
      end
      cyc();
    end
    idle();
    #1;
    chk("oor_pre", 32'(oor_err), 32'd0);
    m0_req(0, 1, 13'h1400, 4'hF, 32'hFFFF_FFFF);
    #1;
    chk("oor_cs", 32'(ram_chipselect), 32'd1);
    chk("oor_ramwr", 32'(ram_write), 32'd0);
    chk("oor_w0", 32'(m0_waitrequest), 32'd0);
    chk("oor_same", 32'(oor_err), 32'd0);
    cyc();
    m0_req(1, 0, 13'h1400, 4'hF, 32'h0);
    #1;
    chk("oor_set", 32'(oor_err), 32'd1);
    cyc();
    idle();
    #1;
    chk("oor_v0", 32'(m0_readdatavalid), 32'd1);
    chk("oor_d0", m0_readdata, 32'h0);
    cyc();
    cyc();
    chk("oor_sticky", 32'(oor_err), 32'd1);
    // reset right after an accepted m1 read discards the pending return
    m1_req(1, 0, 13'h010, 4'hF, 32'h0);
    #1;
    chk("rr_w1", 32'(m1_waitrequest), 32'd0);
    cyc();
    reset_n = 1'b0;
    idle();
    #1;
    chk_reset_state("rr");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rr_rel_v1", 32'(m1_readdatavalid), 32'd0);
    cyc();
    chk("rr_post_v1", 32'(m1_readdatavalid), 32'd0);
    chk("rr_post_oor", 32'(oor_err), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
